// File: rtl/arbitro_rr_pcie.sv
// Purpose: round-robin arbiter that moves words from four input FIFOs (0..3)
//          to four output FIFOs (4..7), routed by data bits [9:8].
// Latency: pop_in is registered; push_out/data_out follow the pop by 1 cycle.
// Backpressure: a source is skipped while empty or while its destination is almost full.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   init                  configuration request (enter INIT, load thresholds)
//   umbral_L_in/_H_in     threshold values captured while in INIT with init=1
//   fifo_empty[3:0]       empty flags of input FIFOs 0..3
//   data_in0..3           first-word-fall-through head of each input FIFO
//   almost_full[3:0]      almost-full flags of output FIFOs 4..7 (bit j = FIFO 4+j)
//   pop_in[3:0]           one-hot pop to input FIFO k (registered)
//   push_out[3:0]         one-hot push to output FIFO 4+j (registered)
//   data_out              word accompanying push_out (registered, held when idle)
//   umbral_L/umbral_H     thresholds broadcast to the output FIFOs (registered)
//   estado[3:0]           one-hot state RESET/INIT/IDLE/ACTIVE
//   pkt_count[15:0]       words pushed since reset, wraps at 16 bits
module arbitro_rr_pcie #(
  // Data width; must be at least 10 because the destination lives in [9:8].
  parameter int TAMANO_DATOS = 12,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_L_in,
  input  logic [UMBRALES_L_H-1:0] umbral_H_in,
  input  logic [3:0]              fifo_empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic [3:0]              almost_full,
  output logic [3:0]              pop_in,
  output logic [3:0]              push_out,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [UMBRALES_L_H-1:0] umbral_L,
  output logic [UMBRALES_L_H-1:0] umbral_H,
  output logic [3:0]              estado,
  output logic [15:0]             pkt_count
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } estado_e;

  estado_e                 estado_q, estado_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [3:0]              pop_in_q, pop_in_d;
  // Binary index of the source being popped, so the push stage needs no encoder.
  logic [1:0]              pop_idx_q, pop_idx_d;
  logic [3:0]              push_out_q, push_out_d;
  logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
  logic [UMBRALES_L_H-1:0] umbral_l_q, umbral_l_d;
  logic [UMBRALES_L_H-1:0] umbral_h_q, umbral_h_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic [TAMANO_DATOS-1:0] head [4];
  logic [1:0]              dest [4];
  logic [3:0]              elegible;
  logic                    gnt_vld;
  logic [1:0]              gnt_idx;
  logic [1:0]              cand;

  assign head[0] = data_in0;
  assign head[1] = data_in1;
  assign head[2] = data_in2;
  assign head[3] = data_in3;

  // Destination and eligibility per source, taken from the current head word.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dest[k]     = head[k][9:8];
      elegible[k] = ~fifo_empty[k] & ~almost_full[dest[k]];
    end
  end

  // First eligible source starting at rr_ptr and wrapping modulo 4.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!gnt_vld && elegible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= ST_RESET;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic; init always wins so software can reconfigure at any time.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_RESET: begin
        estado_d = ST_INIT;
      end
      ST_INIT: begin
        if (!init) begin
          estado_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (init) begin
          estado_d = ST_INIT;
        end else if (!(&fifo_empty)) begin
          estado_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          estado_d = ST_INIT;
        end else if (&fifo_empty) begin
          estado_d = ST_IDLE;
        end
      end
      default: begin
        estado_d = ST_RESET;
      end
    endcase
  end

  // Datapath next values.
  always_comb begin
    pop_in_d    = 4'b0000;
    pop_idx_d   = pop_idx_q;
    rr_ptr_d    = rr_ptr_q;
    push_out_d  = 4'b0000;
    data_out_d  = data_out_q;
    umbral_l_d  = umbral_l_q;
    umbral_h_d  = umbral_h_q;
    pkt_count_d = pkt_count_q;

    // Grant decided now, pop presented next cycle; the pointer only moves on a grant.
    if ((estado_q == ST_ACTIVE) && !init && gnt_vld) begin
      pop_in_d  = 4'b0001 << gnt_idx;
      pop_idx_d = gnt_idx;
      rr_ptr_d  = gnt_idx + 2'd1;
    end

    // The head is valid during the pop cycle, so the word and its route are
    // captured here. This is independent of the state, so a push already in
    // flight still completes when the FSM leaves ACTIVE.
    if (|pop_in_q) begin
      push_out_d = 4'b0001 << dest[pop_idx_q];
      data_out_d = head[pop_idx_q];
    end

    if ((estado_q == ST_INIT) && init) begin
      umbral_l_d = umbral_L_in;
      umbral_h_d = umbral_H_in;
    end

    // Count the push on the cycle it is visible on push_out; wraps naturally.
    if (|push_out_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  // Datapath registers; reset drops any in-flight push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= 2'd0;
      pop_in_q    <= 4'b0000;
      pop_idx_q   <= 2'd0;
      push_out_q  <= 4'b0000;
      data_out_q  <= '0;
      umbral_l_q  <= '0;
      umbral_h_q  <= '0;
      pkt_count_q <= 16'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pop_in_q    <= pop_in_d;
      pop_idx_q   <= pop_idx_d;
      push_out_q  <= push_out_d;
      data_out_q  <= data_out_d;
      umbral_l_q  <= umbral_l_d;
      umbral_h_q  <= umbral_h_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pop_in    = pop_in_q;
  assign push_out  = push_out_q;
  assign data_out  = data_out_q;
  assign umbral_L  = umbral_l_q;
  assign umbral_H  = umbral_h_q;
  assign estado    = estado_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_arbitro_rr_pcie.sv
// Bench for arbitro_rr_pcie: behavioural input FIFOs, a push scoreboard and
// directed scenarios for configuration, rotation, backpressure and reset.
module tb_arbitro_rr_pcie;

  localparam int DW = 12;
  localparam int TW = 8;

  logic          clk;
  logic          reset;
  logic          init;
  logic [TW-1:0] umbral_L_in, umbral_H_in;
  logic [3:0]    fifo_empty, almost_full;
  logic [DW-1:0] d_in [4];
  logic [3:0]    pop_in, push_out, estado;
  logic [DW-1:0] data_out;
  logic [TW-1:0] umbral_L, umbral_H;
  logic [15:0]   pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  // Input FIFO model: storage, read pointer and occupancy per source.
  logic [DW-1:0] fmem [4][16];
  int            frd  [4];
  int            fcnt [4];

  typedef struct packed {
    logic [3:0]    push;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          exp_q [$];
  logic [3:0]    pop_seen;
  logic [15:0]   exp_pkt;
  logic [DW-1:0] exp_last;

  arbitro_rr_pcie #(.TAMANO_DATOS(DW), .UMBRALES_L_H(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_L_in (umbral_L_in),
    .umbral_H_in (umbral_H_in),
    .fifo_empty  (fifo_empty),
    .data_in0    (d_in[0]),
    .data_in1    (d_in[1]),
    .data_in2    (d_in[2]),
    .data_in3    (d_in[3]),
    .almost_full (almost_full),
    .pop_in      (pop_in),
    .push_out    (push_out),
    .data_out    (data_out),
    .umbral_L    (umbral_L),
    .umbral_H    (umbral_H),
    .estado      (estado),
    .pkt_count   (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Empty flag already accounts for a pop in progress on the last word, so the
  // registered pop never reaches an empty FIFO.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fifo_empty[k] = (fcnt[k] == 0) || ((fcnt[k] == 1) && pop_in[k]);
      d_in[k]       = fmem[k][frd[k]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input logic [1:0] dst);
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 4095));
    w[9:8] = dst;
    return w;
  endfunction

  task automatic fifo_load(input int k, input logic [DW-1:0] w);
    fmem[k][(frd[k] + fcnt[k]) % 16] = w;
    fcnt[k]++;
  endtask

  task automatic sb_clear();
    exp_q.delete();
    pop_seen = 4'b0000;
    exp_pkt  = 16'd0;
    exp_last = '0;
  endtask

  // Runs at the falling edge: compare pushes, then record new pops.
  task automatic monitor();
    exp_t          e;
    logic [DW-1:0] w;
    check_eq("pop_onehot0", {31'd0, $onehot0(pop_in)}, 32'd1);
    check_eq("pkt_count", pkt_count, exp_pkt);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("push_dest", push_out, e.push);
      check_eq("push_data", data_out, e.dat);
      exp_pkt  = exp_pkt + 16'd1;
      exp_last = e.dat;
    end else begin
      check_eq("push_idle", push_out, 4'b0000);
      check_eq("data_hold", data_out, exp_last);
    end
    pop_seen = pop_in;
    for (int k = 0; k < 4; k++) begin
      if (pop_in[k]) begin
        check_eq("pop_nonempty", (fcnt[k] > 0), 1);
        w      = fmem[k][frd[k]];
        e.push = 4'b0001 << w[9:8];
        e.dat  = w;
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: retire the FIFO pops just after the rising edge, then monitor.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pop_seen[k] && (fcnt[k] > 0)) begin
        frd[k] = (frd[k] + 1) % 16;
        fcnt[k]--;
      end
    end
    pop_seen = 4'b0000;
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string tag);
    int n;
    int left;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && (n < 60)) begin
      cyc();
      n++;
      left = 0;
      for (int k = 0; k < 4; k++) left += fcnt[k];
      done = (left == 0) && (exp_q.size() == 0) && (estado == 4'b0100);
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    #1;
    check_eq("rst_push", push_out, 4'b0000);
    check_eq("rst_pkt", pkt_count, 16'd0);
    sb_clear();
    cyc();
    reset = 1'b0;
    cyc();
    init = 1'b1;
    cyc();
    init = 1'b0;
    cyc();
    check_eq("reinit_idle", estado, 4'b0100);
    check_eq("reinit_umbral_H", umbral_H, 8'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq34 [5];
    logic [3:0] seq35 [6];
    logic [3:0] post  [12];
    int         first;

    seq34 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq35 = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};

    for (int k = 0; k < 4; k++) begin
      frd[k]  = 0;
      fcnt[k] = 0;
      for (int j = 0; j < 16; j++) fmem[k][j] = '0;
    end
    reset       = 1'b1;
    init        = 1'b0;
    umbral_L_in = '0;
    umbral_H_in = '0;
    almost_full = 4'b0000;
    sb_clear();

    // Reset values and configuration sequence.
    @(negedge clk);
    cyc();
    check_eq("rst_estado", estado, 4'b0001);
    check_eq("rst_pop", pop_in, 4'b0000);
    check_eq("rst_data", data_out, 12'h000);
    check_eq("rst_L", umbral_L, 8'd0);
    check_eq("rst_H", umbral_H, 8'd0);
    reset = 1'b0;
    cyc();
    check_eq("enter_init", estado, 4'b0010);
    init = 1'b1; umbral_H_in = 8'd6; umbral_L_in = 8'd0;
    cyc();
    check_eq("cfg1_H", umbral_H, 8'd6);
    check_eq("cfg1_L", umbral_L, 8'd0);
    umbral_H_in = 8'd5; umbral_L_in = 8'd1;
    cyc();
    check_eq("cfg2_H", umbral_H, 8'd5);
    check_eq("cfg2_L", umbral_L, 8'd1);
    init = 1'b0;
    cyc();
    check_eq("enter_idle", estado, 4'b0100);
    check_eq("cfg_H", umbral_H, 8'd5);
    check_eq("cfg_L", umbral_L, 8'd1);
    cyc();
    check_eq("idle_empty", estado, 4'b0100);

    // Single word from FIFO 0 routed to FIFO 5.
    fifo_load(0, 12'h1FB);
    cyc();
    check_eq("single_active", estado, 4'b1000);
    check_eq("single_nopop", pop_in, 4'b0000);
    cyc();
    check_eq("single_pop", pop_in, 4'b0001);
    cyc();
    check_eq("single_push", push_out, 4'b0010);
    check_eq("single_data", data_out, 12'h1FB);
    cyc();
    check_eq("single_pkt", pkt_count, 16'd1);
    check_eq("single_idle", estado, 4'b0100);

    // Full rotation with every source ready.
    reset_and_init();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) fifo_load(k, mk_word(2'(k + 1)));
    cyc();
    check_eq("rr_active", estado, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("rr_seq", pop_in, seq34[i]);
    end
    drain("rr_drained");

    // Source 1 blocked by almost_full on FIFO 6.
    almost_full = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      fifo_load(0, mk_word(2'b00));
      fifo_load(2, mk_word(2'b01));
      fifo_load(3, mk_word(2'b11));
    end
    fifo_load(1, mk_word(2'b10));
    fifo_load(1, mk_word(2'b10));
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_eq("bp_seq", pop_in, seq35[i]);
    end
    almost_full = 4'b0000;
    cyc();
    check_eq("bp_turn0", pop_in, 4'b0001);
    cyc();
    check_eq("bp_src1", pop_in, 4'b0010);
    drain("bp_drained");

    // init during ACTIVE with a pop outstanding.
    for (int j = 0; j < 3; j++) fifo_load(2, mk_word(2'b11));
    cyc();
    cyc();
    check_eq("cfg_act_pop", pop_in, 4'b0100);
    init = 1'b1; umbral_H_in = 8'd7; umbral_L_in = 8'd2;
    cyc();
    check_eq("cfg_act_nopop", pop_in, 4'b0000);
    check_eq("cfg_act_estado", estado, 4'b0010);
    check_eq("cfg_act_push", push_out, 4'b1000);
    check_eq("cfg_act_H_old", umbral_H, 8'd5);
    cyc();
    check_eq("cfg_act_H", umbral_H, 8'd7);
    check_eq("cfg_act_L", umbral_L, 8'd2);
    init = 1'b0;
    cyc();
    check_eq("cfg_act_idle", estado, 4'b0100);
    cyc();
    cyc();
    check_eq("pre_rst_pop", pop_in, 4'b0100);

    // Reset mid-operation drops the in-flight push.
    reset = 1'b1;
    #1;
    check_eq("mid_rst_estado", estado, 4'b0001);
    check_eq("mid_rst_pop", pop_in, 4'b0000);
    check_eq("mid_rst_push", push_out, 4'b0000);
    check_eq("mid_rst_data", data_out, 12'h000);
    check_eq("mid_rst_H", umbral_H, 8'd0);
    check_eq("mid_rst_L", umbral_L, 8'd0);
    check_eq("mid_rst_pkt", pkt_count, 16'd0);
    sb_clear();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      post[i] = pop_in;
    end
    first = -1;
    for (int i = 0; i < 11; i++) begin
      if ((first < 0) && (post[i] != 4'b0000)) first = i;
    end
    check_eq("post_rst_first", first, 3);
    if (first >= 0) begin
      check_eq("b2b_pop0", post[first], 4'b0100);
      check_eq("b2b_pop1", post[first + 1], 4'b0100);
    end
    drain("final_drained");
    check_eq("final_pkt", pkt_count, 16'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
